inst_buffer: RTL and testbench
==============================

// Module: inst_buffer
// PURPOSE
//  Instruction store serving the NPU instruction fetch port (pc / rd_en -> 128-bit inst + valid).
//  Host side loads the program as 32-bit writes; four lanes are assembled into one 128-bit entry.
//  Sits between the host register/AXI-lite bridge and the NPU instruction controller.
//  Fetch side is read-only; host loading is locked out while the NPU is running.
// PARAMETERS
//  AW      12    entry address width (matches fetch pc width)
//  DEPTH   1024  number of 128-bit entries implemented (DEPTH <= 2**AW)
// PORTS
//  i_clk           in   1    clock
//  i_rst_n         in   1    asynchronous active-low reset
//  i_clr           in   1    sync pulse: clear staging, error flags, load counter
//  i_npu_idle      in   1    1 = NPU idle, host loading allowed
//  i_wr_en         in   1    host write strobe (one 32-bit lane per cycle)
//  i_wr_addr       in   AW+2 host word address: [AW+1:2] entry, [1:0] lane (lane 0 = inst[31:0])
//  i_wr_data       in   32   host write data
//  i_pc            in   AW   fetch address from instruction controller
//  i_rd_en         in   1    fetch request
//  o_inst          out  128  fetched instruction
//  o_inst_valid    out  1    1-cycle pulse: o_inst valid
//  o_load_cnt      out  AW+1 entries committed since reset/i_clr (saturates at 2**(AW+1)-1)
//  o_load_err      out  1    sticky: partial/interleaved entry or write while busy
//  o_rd_err        out  1    sticky: fetch with i_pc >= DEPTH
// BEHAVIOUR
//  Reset: o_inst=0, o_inst_valid=0, o_load_cnt=0, o_load_err=0, o_rd_err=0, staging cleared.
//   Storage array is not reset.
//  Write assembly:
//   - staging reg 96 bit (lanes 0-2), 3-bit lane mask, stored entry index stg_idx.
//   - lane 0-2 write: store lane, set mask bit; if mask nonzero and entry != stg_idx,
//     set o_load_err, restart staging with this lane (old lanes dropped).
//   - lane 3 write: commit {data, lane2, lane1, lane0} to entry same cycle (visible next cycle);
//     if mask != 3'b111 or entry != stg_idx, set o_load_err, still commit (missing lanes = 0);
//     clear mask; o_load_cnt += 1.
//   - entry >= DEPTH: write dropped, o_load_err set, staging unchanged.
//   - i_wr_en while i_npu_idle=0: write dropped entirely, o_load_err set.
//  Fetch:
//   - i_rd_en at cycle N -> o_inst/o_inst_valid at N+1 (latency 1, one request per cycle,
//     back-to-back supported, no backpressure).
//   - o_inst holds last value when o_inst_valid=0.
//   - i_pc >= DEPTH: o_inst=0 with o_inst_valid=1, o_rd_err set.
//   - commit and fetch of same entry in same cycle: fetch returns OLD contents (read-first).
//  i_clr: mask, o_load_cnt, o_load_err, o_rd_err -> 0 next cycle; has priority over a
//   simultaneous write/error in that cycle (the write itself is still dropped from staging,
//   but a lane-3 commit to the array still occurs). Does not affect fetch pipeline.
//  Reset mid-operation: pending valid killed, staging lost; array contents retained.
// TESTING
//  1 Write lanes 0..3 of entry 5 with 0x11111111..0x44444444, then rd pc=5 -> next cycle
//    o_inst=0x44444444_33333333_22222222_11111111, valid=1 for 1 cycle, o_load_cnt=1.
//  2 Back-to-back rd pc=0,1,2 cycles N..N+2 -> valid N+1..N+3 with entries 0,1,2 in order.
//  3 Lane 0,1 to entry 2 then lane 3 to entry 2 -> committed with lane2=0, o_load_err=1;
//    i_clr -> o_load_err=0, o_load_cnt=0.
//  4 i_npu_idle=0, write lane 3 entry 7 -> entry 7 unchanged, o_load_err=1, o_load_cnt unchanged.
//  5 Same cycle lane-3 commit to entry 9 and rd pc=9 -> old data; rd pc=9 next cycle -> new data.
//  6 rd pc=DEPTH (1024) -> o_inst=0, valid=1, o_rd_err=1; assert i_rst_n=0 with fetch in
//    flight -> o_inst_valid=0, all flags 0, previously loaded entries still readable.

Source files
------------

// File: rtl/inst_buffer.sv
// Instruction store: host loads 32-bit lanes that are assembled into 128-bit entries,
// and the NPU fetch port reads one entry per request with a one-cycle latency.
module inst_buffer #(
  parameter int AW    = 12,
  parameter int DEPTH = 1024
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_npu_idle,
  input  logic          i_wr_en,
  input  logic [AW+1:0] i_wr_addr,
  input  logic [31:0]   i_wr_data,
  input  logic [AW-1:0] i_pc,
  input  logic          i_rd_en,
  output logic [127:0]  o_inst,
  output logic          o_inst_valid,
  output logic [AW:0]   o_load_cnt,
  output logic          o_load_err,
  output logic          o_rd_err
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [127:0]  mem [DEPTH];
  logic [31:0]   stg_lane [3];
  logic [2:0]    stg_mask;
  logic [AW-1:0] stg_idx;

  logic [AW-1:0] entry;
  logic [1:0]    lane;
  logic          entry_ok;
  logic          pc_ok;
  logic          commit;
  logic          stage_wr;
  logic          err_set;
  logic [2:0]    mask_nxt;
  logic [2:0]    keep;
  logic [127:0]  commit_data;

  assign entry    = i_wr_addr[AW+1:2];
  assign lane     = i_wr_addr[1:0];
  assign entry_ok = {1'b0, entry} < DEPTH_W;
  assign pc_ok    = {1'b0, i_pc} < DEPTH_W;

  // Staged lanes only count toward a commit when they belong to the committed entry.
  assign keep        = (entry == stg_idx) ? stg_mask : 3'b000;
  assign commit_data = {i_wr_data,
                        stg_lane[2] & {32{keep[2]}},
                        stg_lane[1] & {32{keep[1]}},
                        stg_lane[0] & {32{keep[0]}}};

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    commit   = 1'b0;
    stage_wr = 1'b0;
    err_set  = 1'b0;
    mask_nxt = stg_mask;
    if (i_wr_en) begin
      if (!i_npu_idle || !entry_ok) begin
        err_set = 1'b1;
      end else if (lane == 2'd3) begin
        commit   = 1'b1;
        mask_nxt = 3'b000;
        if (stg_mask != 3'b111 || entry != stg_idx) err_set = 1'b1;
      end else begin
        stage_wr = 1'b1;
        if (stg_mask != 3'b000 && entry != stg_idx) begin
          err_set  = 1'b1;
          mask_nxt = 3'b001 << lane;
        end else begin
          mask_nxt = stg_mask | (3'b001 << lane);
        end
      end
    end
  end

  // NOTE: the instruction array has no reset so it maps onto plain RAM and survives i_rst_n.
  always_ff @(posedge i_clk) begin
    if (commit) mem[entry[IW-1:0]] <= commit_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stg_mask   <= '0;
      stg_idx    <= '0;
      stg_lane   <= '{default: '0};
      o_load_cnt <= '0;
      o_load_err <= 1'b0;
      o_rd_err   <= 1'b0;
    end else if (i_clr) begin
      stg_mask   <= '0;
      o_load_cnt <= '0;
      o_load_err <= 1'b0;
      o_rd_err   <= 1'b0;
    end else begin
      stg_mask <= mask_nxt;
      if (stage_wr) begin
        stg_idx <= entry;
        for (int i = 0; i < 3; i++) begin
          if (lane == 2'(i)) stg_lane[i] <= i_wr_data;
        end
      end
      if (commit && o_load_cnt != '1) o_load_cnt <= o_load_cnt + 1'b1;
      if (err_set) o_load_err <= 1'b1;
      if (i_rd_en && !pc_ok) o_rd_err <= 1'b1;
    end
  end

  // Read-first: the array write above lands after this read samples the old contents.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_inst       <= '0;
      o_inst_valid <= 1'b0;
    end else begin
      o_inst_valid <= i_rd_en;
      if (i_rd_en) o_inst <= pc_ok ? mem[i_pc[IW-1:0]] : '0;
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: directed scenarios plus randomized host loads and
// fetches compared against an entry-level reference model.
module tb_inst_buffer;

  localparam int AW      = 12;
  localparam int DEPTH   = 1024;
  localparam int CNT_MAX = (1 << (AW + 1)) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr, npu_idle, wr_en, rd_en;
  logic [AW+1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW-1:0] pc;
  logic [127:0]  inst;
  logic          inst_valid, load_err, rd_err;
  logic [AW:0]   load_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [127:0] ref_mem [DEPTH];
  bit           ref_known [DEPTH];
  logic [31:0]  m_lane [3];
  bit   [2:0]   m_mask;
  int           m_idx, m_cnt;
  bit           m_err, m_rd_err, m_valid;
  logic [127:0] m_inst;

  inst_buffer #(.AW(AW), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_npu_idle(npu_idle),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_pc(pc), .i_rd_en(rd_en),
    .o_inst(inst), .o_inst_valid(inst_valid), .o_load_cnt(load_cnt),
    .o_load_err(load_err), .o_rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mask = 0; m_idx = 0; m_cnt = 0;
    m_err = 0; m_rd_err = 0; m_valid = 0; m_inst = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock cycle of stimulus; the model is updated with the same request.
  task automatic step(input bit wr, input int entry, input int lane, input logic [31:0] d,
                      input bit rd, input int pc_v, input bit clr_v = 0, input bit idle = 1);
    logic [127:0] v;
    int e;
    e        = entry;
    wr_en    = wr;
    wr_addr  = {e[AW-1:0], 2'(lane)};
    wr_data  = d;
    rd_en    = rd;
    pc       = AW'(pc_v);
    clr      = clr_v;
    npu_idle = idle;
    // fetch sees the array before this cycle's commit
    m_valid = rd;
    if (rd) begin
      if (pc_v < DEPTH) m_inst = ref_mem[pc_v];
      else begin m_inst = '0; m_rd_err = 1; end
    end
    if (wr) begin
      if (!idle || entry >= DEPTH) begin
        m_err = 1;
      end else if (lane < 3) begin
        if (m_mask != 0 && entry != m_idx) begin m_err = 1; m_mask = 0; end
        m_lane[lane] = d;
        m_mask[lane] = 1;
        m_idx = entry;
      end else begin
        v = {d, 96'b0};
        if (entry == m_idx)
          for (int i = 0; i < 3; i++) if (m_mask[i]) v[i*32 +: 32] = m_lane[i];
        if (m_mask != 3'b111 || entry != m_idx) m_err = 1;
        ref_mem[entry] = v;
        ref_known[entry] = 1;
        m_mask = 0;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
    if (clr_v) begin m_mask = 0; m_cnt = 0; m_err = 0; m_rd_err = 0; end
    tick();
    wr_en = 0; rd_en = 0; clr = 0; npu_idle = 1;
  endtask

  task automatic load_entry(input int entry, input logic [127:0] val);
    for (int l = 0; l < 4; l++) step(1, entry, l, val[l*32 +: 32], 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 0; clr = 0; npu_idle = 1; wr_en = 0; rd_en = 0;
    wr_addr = '0; wr_data = '0; pc = '0;
    model_reset();
    repeat (3) tick();
    total++; if (inst !== 128'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", inst); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    total++; if (load_cnt !== '0 || load_err !== 1'b0 || rd_err !== 1'b0) begin
      bad++; $display("FAIL reset_flags cnt=%0d lerr=%b rerr=%b exp=0/0/0", load_cnt, load_err, rd_err);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    step(1, 5, 0, 32'h11111111, 0, 0);
    step(1, 5, 1, 32'h22222222, 0, 0);
    step(1, 5, 2, 32'h33333333, 0, 0);
    step(1, 5, 3, 32'h44444444, 0, 0);
    step(0, 0, 0, 0, 1, 5);
    total++; if (inst !== 128'h44444444_33333333_22222222_11111111 || inst_valid !== 1'b1) begin
      bad++; $display("FAIL basic_fetch got=%h v=%b exp=44444444333333332222222211111111 v=1", inst, inst_valid);
    end
    total++; if (load_cnt !== 13'd1 || load_err !== 1'b0) begin
      bad++; $display("FAIL basic_cnt cnt=%0d err=%b exp=1/0", load_cnt, load_err);
    end
    step(0, 0, 0, 0, 0, 0);
    total++; if (inst_valid !== 1'b0 || inst !== 128'h44444444_33333333_22222222_11111111) begin
      bad++; $display("FAIL basic_hold got=%h v=%b exp hold v=0", inst, inst_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int e = 0; e < 3; e++) load_entry(e, {$urandom, $urandom, $urandom, $urandom});
    for (int e = 0; e < 3; e++) begin
      step(0, 0, 0, 0, 1, e);
      total++; if (inst !== m_inst || inst_valid !== 1'b1) begin
        bad++; $display("FAIL b2b_%0d got=%h v=%b exp=%h v=1", e, inst, inst_valid, m_inst);
      end
    end
    step(0, 0, 0, 0, 0, 0);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL b2b_end v=%b exp=0", inst_valid); end
  endtask

  task automatic test_partial();
    step(1, 2, 0, 32'haaaa0000, 0, 0);
    step(1, 2, 1, 32'hbbbb1111, 0, 0);
    step(1, 2, 3, 32'hdddd3333, 0, 0);
    step(0, 0, 0, 0, 1, 2);
    total++; if (inst !== 128'hdddd3333_00000000_bbbb1111_aaaa0000) begin
      bad++; $display("FAIL partial_data got=%h exp=dddd333300000000bbbb1111aaaa0000", inst);
    end
    total++; if (load_err !== 1'b1) begin bad++; $display("FAIL partial_err got=%b exp=1", load_err); end
    step(0, 0, 0, 0, 0, 0, 1);
    total++; if (load_err !== 1'b0 || load_cnt !== '0) begin
      bad++; $display("FAIL partial_clr err=%b cnt=%0d exp=0/0", load_err, load_cnt);
    end
  endtask

  task automatic test_busy();
    int cnt_before;
    load_entry(7, 128'h7777_0000_7777_1111_7777_2222_7777_3333);
    cnt_before = m_cnt;
    step(1, 7, 3, 32'hdeadbeef, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7);
    total++; if (inst !== 128'h7777_0000_7777_1111_7777_2222_7777_3333) begin
      bad++; $display("FAIL busy_data got=%h exp=77770000777711117777222277773333", inst);
    end
    total++; if (load_err !== 1'b1 || load_cnt !== (AW+1)'(cnt_before)) begin
      bad++; $display("FAIL busy_flags err=%b cnt=%0d exp=1/%0d", load_err, load_cnt, cnt_before);
    end
  endtask

  task automatic test_read_first();
    logic [127:0] old_v, new_v;
    old_v = {$urandom, $urandom, $urandom, $urandom};
    new_v = {$urandom, $urandom, $urandom, $urandom};
    load_entry(9, old_v);
    for (int l = 0; l < 3; l++) step(1, 9, l, new_v[l*32 +: 32], 0, 0);
    step(1, 9, 3, new_v[127:96], 1, 9);
    total++; if (inst !== old_v) begin bad++; $display("FAIL rf_old got=%h exp=%h", inst, old_v); end
    step(0, 0, 0, 0, 1, 9);
    total++; if (inst !== new_v) begin bad++; $display("FAIL rf_new got=%h exp=%h", inst, new_v); end
  endtask

  task automatic test_random();
    int seq_e = 16, seq_l = 0;
    int e, l, p;
    bit wr, rd, c, idle;
    for (int n = 0; n < 600; n++) begin
      wr = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 80) begin
        e = seq_e; l = seq_l;
        seq_l = (seq_l + 1) % 4;
        if (seq_l == 0) seq_e = 16 + $urandom_range(0, 15);
      end else begin
        e = ($urandom_range(0, 19) == 0) ? DEPTH + $urandom_range(0, 3) : 16 + $urandom_range(0, 15);
        l = $urandom_range(0, 3);
      end
      rd = ($urandom_range(0, 1) == 1);
      p  = $urandom_range(0, 40);
      if (p >= 32 || !ref_known[p]) p = DEPTH + $urandom_range(0, 7);
      c    = ($urandom_range(0, 99) < 3);
      idle = ($urandom_range(0, 99) >= 5);
      step(wr, e, l, $urandom, rd, p, c, idle);
      total++;
      if (inst !== m_inst || inst_valid !== m_valid || load_cnt !== (AW+1)'(m_cnt) ||
          load_err !== m_err || rd_err !== m_rd_err) begin
        bad++;
        $display("FAIL rand_%0d inst=%h v=%b cnt=%0d lerr=%b rerr=%b exp inst=%h v=%b cnt=%0d lerr=%b rerr=%b",
                 n, inst, inst_valid, load_cnt, load_err, rd_err, m_inst, m_valid, m_cnt, m_err, m_rd_err);
      end
    end
  endtask

  task automatic test_rd_err_reset();
    logic [127:0] keep5;
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, DEPTH);
    total++; if (inst !== 128'h0 || inst_valid !== 1'b1 || rd_err !== 1'b1) begin
      bad++; $display("FAIL oob_fetch inst=%h v=%b rerr=%b exp=0/1/1", inst, inst_valid, rd_err);
    end
    keep5 = ref_mem[5];
    rd_en = 1; pc = AW'(5);
    tick();
    #2 rst_n = 0;
    #1;
    model_reset();
    total++; if (inst_valid !== 1'b0 || inst !== 128'h0 || load_cnt !== '0 || load_err !== 1'b0 || rd_err !== 1'b0) begin
      bad++; $display("FAIL async_rst v=%b inst=%h cnt=%0d lerr=%b rerr=%b exp all 0",
                      inst_valid, inst, load_cnt, load_err, rd_err);
    end
    rd_en = 0;
    tick();
    rst_n = 1;
    tick();
    step(0, 0, 0, 0, 1, 5);
    total++; if (inst !== keep5 || inst_valid !== 1'b1) begin
      bad++; $display("FAIL retained got=%h v=%b exp=%h v=1", inst, inst_valid, keep5);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_partial();
    test_busy();
    test_read_first();
    test_random();
    test_rd_err_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
